// File: rtl/uart_ram_pkg.sv
// Shared types and constants for the UART command responder: FSM states, opcodes, reply codes.
package uart_ram_pkg;

    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;
    localparam logic [7:0] REPLY_ACK = 8'h4B;
    localparam logic [7:0] REPLY_ERR = 8'h45;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_SEND,
        ST_TX_HOLD,
        ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/frame_timeout.sv
// Saturating inter-byte counter; expired_c is high once LIMIT idle cycles have elapsed.
module frame_timeout #(
    parameter int unsigned LIMIT = 2700000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = (count == CNT_MAX);

endmodule

// File: rtl/uart_ram_cmd_writer.sv
// Parses W/R host frames from the UART receiver, accesses the 16x8 RAM and sends one reply byte.
// Build option: define UART_RAM_CMD_WR_ACK_EN to acknowledge successful writes with 'K'.
module uart_ram_cmd_writer
    import uart_ram_pkg::*;
#(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2700000,
    parameter logic [7:0]  OP_WRITE       = OPC_WRITE,
    parameter logic [7:0]  OP_READ        = OPC_READ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_di,
    output logic              ram_wre,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              overrun
);

    state_t            state, state_n;
    logic              op_write, op_write_n;
    logic [7:0]        tx_data_n;
    logic              tx_start_n;
    logic [ADDR_W-1:0] ram_ad_n;
    logic [DATA_W-1:0] ram_di_n;
    logic              ram_wre_n;
    logic              overrun_n;
    logic              in_frame_c;
    logic              busy_c;
    logic              addr_bad_c;
    logic              expired_c;

    assign in_frame_c = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign busy_c     = !in_frame_c && (state != ST_IDLE);
    assign addr_bad_c = (32'(rx_data) >= (32'd1 << ADDR_W));

    frame_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (rx_valid || !in_frame_c),
        .enable   (in_frame_c),
        .expired_c(expired_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_write <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            ram_ad   <= '0;
            ram_di   <= '0;
            ram_wre  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            op_write <= op_write_n;
            tx_data  <= tx_data_n;
            tx_start <= tx_start_n;
            ram_ad   <= ram_ad_n;
            ram_di   <= ram_di_n;
            ram_wre  <= ram_wre_n;
            overrun  <= overrun_n;
        end
    end

    // Next-state and next-output logic; a byte arriving while busy only sets overrun.
    always_comb begin
        state_n    = state;
        op_write_n = op_write;
        tx_data_n  = tx_data;
        tx_start_n = 1'b0;
        ram_ad_n   = ram_ad;
        ram_di_n   = ram_di;
        ram_wre_n  = 1'b0;
        overrun_n  = overrun || (rx_valid && busy_c);

        unique case (state)
            ST_IDLE: begin
                if (rx_valid && ((rx_data == OP_WRITE) || (rx_data == OP_READ))) begin
                    op_write_n = (rx_data == OP_WRITE);
                    state_n    = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid) begin
                    if (addr_bad_c) begin
                        tx_data_n  = REPLY_ERR;
                        tx_start_n = 1'b1;
                        state_n    = ST_SEND;
                    end else begin
                        ram_ad_n = ADDR_W'(rx_data);
                        state_n  = op_write ? ST_GET_DATA : ST_RD_WAIT;
                    end
                end else if (expired_c) begin
                    state_n = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_valid) begin
                    ram_di_n = DATA_W'(rx_data);
                    state_n  = ST_WRITE;
                end else if (expired_c) begin
                    state_n = ST_IDLE;
                end
            end
            // Address/data settle for one cycle, then ram_wre pulses once.
            ST_WRITE: begin
                if (!ram_wre) begin
                    ram_wre_n = 1'b1;
                end else begin
`ifdef UART_RAM_CMD_WR_ACK_EN
                    tx_data_n  = REPLY_ACK;
                    tx_start_n = 1'b1;
                    state_n    = ST_SEND;
`else
                    state_n    = ST_IDLE;
`endif
                end
            end
            ST_RD_WAIT: state_n = ST_RD_CAP;
            ST_RD_CAP: begin
                tx_data_n  = 8'(ram_dout);
                tx_start_n = 1'b1;
                state_n    = ST_SEND;
            end
            ST_SEND:    state_n = ST_TX_HOLD;
            ST_TX_HOLD: state_n = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    state_n = ST_IDLE;
                end
            end
            default:    state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_ram_cmd_writer.sv
// Randomised directed bench for uart_ram_cmd_writer with RAM/UART models and a frame-level reference.
module tb_uart_ram_cmd_writer;

    localparam int unsigned T = 100;
`ifdef UART_RAM_CMD_WR_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    typedef struct packed {
        int         cyc;
        logic [3:0] ad;
        logic [7:0] d;
    } wr_ev_t;

    typedef struct packed {
        int         cyc;
        logic [7:0] d;
    } tx_ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [3:0] ram_ad;
    logic [7:0] ram_di;
    logic       ram_wre;
    logic [7:0] ram_dout;
    logic       overrun;

    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    int         busy_left;
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] held;
    bit         exp_ovr;
    wr_ev_t     obs_wr[$], exp_wr[$];
    tx_ev_t     obs_tx[$], exp_tx[$];

    uart_ram_cmd_writer #(
        .ADDR_W(4),
        .DATA_W(8),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy),
        .ram_ad  (ram_ad),
        .ram_di  (ram_di),
        .ram_wre (ram_wre),
        .ram_dout(ram_dout),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with synchronous read; known contents after reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 37 + 11);
        end else begin
            if (ram_wre) mem[ram_ad] <= ram_di;
            ram_dout <= mem[ram_ad];
        end
    end

    // UART transmitter: busy from the cycle after tx_start for a random length.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy   <= 1'b0;
            busy_left <= 0;
        end else if (tx_start) begin
            tx_busy   <= 1'b1;
            busy_left <= int'($urandom_range(6, 2));
        end else if (busy_left != 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) tx_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wre) obs_wr.push_back('{cyc, ram_ad, ram_di});
            if (tx_start) begin
                obs_tx.push_back('{cyc, tx_data});
                held = tx_data;
            end else if (tx_busy) begin
                check("tx_hold", 64'(tx_data), 64'(held));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic void ref_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 37 + 11);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int at);
        idle(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        at       = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic compare(input string tag);
        check({tag, ":wr_n"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        check({tag, ":tx_n"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            check({tag, ":wr"}, 64'(obs_wr[i]), 64'(exp_wr[i]));
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
            check({tag, ":tx"}, 64'(obs_tx[i]), 64'(exp_tx[i]));
        check({tag, ":ovr"}, 64'(overrun), 64'(exp_ovr));
        obs_wr.delete();
        exp_wr.delete();
        obs_tx.delete();
        exp_tx.delete();
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d, input string tag);
        int c0, c1, c2;
        send_byte(8'h57, int'($urandom_range(3, 0)), c0);
        send_byte(a, int'($urandom_range(3, 0)), c1);
        if (a < 8'd16) begin
            send_byte(d, int'($urandom_range(3, 0)), c2);
            exp_wr.push_back('{c2 + 2, a[3:0], d});
            ref_mem[a[3:0]] = d;
            if (ACK_EN) exp_tx.push_back('{c2 + 3, 8'h4B});
            idle(20);
        end else begin
            exp_tx.push_back('{c1 + 1, 8'h45});
            idle(20);
            send_byte(8'h00, 0, c2);
            idle(5);
        end
        compare(tag);
    endtask

    task automatic cmd_read(input logic [7:0] a, input string tag);
        int c0, c1;
        send_byte(8'h52, int'($urandom_range(3, 0)), c0);
        send_byte(a, int'($urandom_range(3, 0)), c1);
        if (a < 8'd16) exp_tx.push_back('{c1 + 3, ref_mem[a[3:0]]});
        else           exp_tx.push_back('{c1 + 1, 8'h45});
        idle(20);
        compare(tag);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!tx_busy && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ":busy"}, 64'(tx_busy), 64'(1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":tx_data"}, 64'(tx_data), 64'(0));
        check({tag, ":tx_start"}, 64'(tx_start), 64'(0));
        check({tag, ":ram_ad"}, 64'(ram_ad), 64'(0));
        check({tag, ":ram_di"}, 64'(ram_di), 64'(0));
        check({tag, ":ram_wre"}, 64'(ram_wre), 64'(0));
        check({tag, ":overrun"}, 64'(overrun), 64'(0));
    endtask

    initial begin
        int c0, c1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_ovr  = 1'b0;
        ref_init();
        idle(3);
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cmd_write(8'h03, 8'hA5, "w03");
        cmd_read(8'h03, "r03");
        cmd_write(8'h1F, 8'h00, "w_bad");
        cmd_read(8'h10, "r_bad");
        cmd_write(8'h04, 8'h11, "w04");
        cmd_read(8'h04, "r04");

        // Unknown opcode in idle is silently dropped.
        send_byte(8'hA3, 0, c0);
        idle(10);
        compare("unk_op");

        // Frame abandoned mid-way times out with no access and no reply.
        send_byte(8'h57, 0, c0);
        send_byte(8'h02, 1, c1);
        idle(T + 10);
        compare("tmo");
        cmd_read(8'h02, "after_tmo");

        // Longest surviving gap, then one cycle too long.
        send_byte(8'h52, 0, c0);
        send_byte(8'h07, T, c1);
        exp_tx.push_back('{c1 + 3, ref_mem[7]});
        idle(20);
        compare("gap_max");
        send_byte(8'h52, 0, c0);
        send_byte(8'h05, T + 1, c1);
        idle(20);
        compare("gap_over");

        // Byte during the reply sets overrun but does not disturb it.
        send_byte(8'h52, 0, c0);
        send_byte(8'h01, 0, c1);
        exp_tx.push_back('{c1 + 3, ref_mem[1]});
        wait_busy("ovr");
        send_byte(8'h57, 0, c0);
        exp_ovr = 1'b1;
        idle(20);
        compare("ovr");
        cmd_read(8'h03, "after_ovr");

        for (int n = 0; n < 24; n++) begin
            int         kind;
            logic [7:0] a, d;
            kind = int'($urandom_range(9, 0));
            a    = 8'($urandom_range(19, 0));
            d    = 8'($urandom);
            if (kind < 4) begin
                cmd_write(a, d, "rnd_w");
            end else if (kind < 8) begin
                cmd_read(a, "rnd_r");
            end else begin
                if (d == 8'h57 || d == 8'h52) d = 8'h00;
                send_byte(d, 0, c0);
                idle(5);
                compare("rnd_unk");
            end
        end

        // Reset in the middle of a reply.
        send_byte(8'h52, 0, c0);
        send_byte(8'h05, 0, c1);
        exp_tx.push_back('{c1 + 3, ref_mem[5]});
        wait_busy("rst_mid");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold:tx_start", 64'(tx_start), 64'(0));
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ovr = 1'b0;
        ref_init();
        @(posedge clk);
        #1;
        compare("rst_mid");
        cmd_read(8'h05, "post_rst");
        cmd_write(8'h0F, 8'h3C, "w0f");
        cmd_read(8'h0F, "r0f");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
